// File: rtl/pcie_tx_arbiter_if.sv
// pcie_tx_arbiter_if
//   Bundles the two TLP source streams (PIO and INJ) and the merged output
//   stream that feeds the PCIe core's s_axis_tx port.
//   slave  : the arbiter's view (sources in, merged stream out).
//   master : the surrounding logic's view (drives sources, sinks output).
interface pcie_tx_arbiter_if #(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8
);

  // PIO completion engine (req/ack plus AXI4-Stream)
  logic                    pio_tx_req;
  logic                    pio_tx_ack;
  logic                    pio_tx_tready;
  logic                    pio_tx_tvalid;
  logic                    pio_tx_tlast;
  logic [KEEP_WIDTH-1:0]   pio_tx_tkeep;
  logic [C_DATA_WIDTH-1:0] pio_tx_tdata;
  logic [3:0]              pio_tx_tuser;

  // Injected TLPs from the Ethernet side (tvalid doubles as request)
  logic                    inj_tx_tready;
  logic                    inj_tx_tvalid;
  logic                    inj_tx_tlast;
  logic [KEEP_WIDTH-1:0]   inj_tx_tkeep;
  logic [C_DATA_WIDTH-1:0] inj_tx_tdata;
  logic [3:0]              inj_tx_tuser;

  // Merged stream towards the PCIe core
  logic                    out_tx_tready;
  logic                    out_tx_tvalid;
  logic                    out_tx_tlast;
  logic [KEEP_WIDTH-1:0]   out_tx_tkeep;
  logic [C_DATA_WIDTH-1:0] out_tx_tdata;
  logic [3:0]              out_tx_tuser;

  modport slave (
    input  pio_tx_req, pio_tx_tvalid, pio_tx_tlast, pio_tx_tkeep, pio_tx_tdata, pio_tx_tuser,
    output pio_tx_ack, pio_tx_tready,
    input  inj_tx_tvalid, inj_tx_tlast, inj_tx_tkeep, inj_tx_tdata, inj_tx_tuser,
    output inj_tx_tready,
    input  out_tx_tready,
    output out_tx_tvalid, out_tx_tlast, out_tx_tkeep, out_tx_tdata, out_tx_tuser
  );

  modport master (
    output pio_tx_req, pio_tx_tvalid, pio_tx_tlast, pio_tx_tkeep, pio_tx_tdata, pio_tx_tuser,
    input  pio_tx_ack, pio_tx_tready,
    output inj_tx_tvalid, inj_tx_tlast, inj_tx_tkeep, inj_tx_tdata, inj_tx_tuser,
    input  inj_tx_tready,
    output out_tx_tready,
    input  out_tx_tvalid, out_tx_tlast, out_tx_tkeep, out_tx_tdata, out_tx_tuser
  );

endinterface

// File: rtl/pcie_tx_arbiter.sv
// pcie_tx_arbiter
//   Merges the PIO completion stream and the injected-TLP stream into the
//   single PCIe TX stream. Arbitration happens only at packet boundaries
//   (round-robin), beats of different TLPs are never interleaved, and the
//   output is registered through a 2-entry skid buffer.
//
//   Build option: define PCIE_TX_ARB_PIO_PRIO_EN to give PIO strict priority
//   in IDLE (bounded completion latency for host reads). Undefined, the
//   arbiter is round-robin.
module pcie_tx_arbiter #(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8
) (
  input  logic                 pcie_clk,
  input  logic                 pcie_rst_n,
  input  logic                 lnk_up,
  pcie_tx_arbiter_if.slave     tx
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_PIO = 2'd1,
    GNT_INJ = 2'd2
  } state_e;

  typedef enum logic {
    SRC_PIO = 1'b0,
    SRC_INJ = 1'b1
  } src_e;

  // One skid-buffer entry: everything that travels with a beat.
  typedef struct packed {
    logic                    last;
    logic [KEEP_WIDTH-1:0]   keep;
    logic [C_DATA_WIDTH-1:0] data;
    logic [3:0]              user;
  } beat_t;

  localparam logic [1:0] CNT_FULL = 2'd2;

  // Arbiter state
  state_e     r_state;
  state_e     w_state_nxt;
  src_e       r_rr_last;
  src_e       w_rr_last_nxt;
  logic       r_pio_ack;

  // Skid buffer state
  beat_t      r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_cnt;

  // Handshake decode
  logic       w_pio_tready;
  logic       w_inj_tready;
  logic       w_pio_acc;
  logic       w_inj_acc;
  logic       w_push;
  logic       w_pop;
  beat_t      w_in_beat;
  beat_t      w_head;

  // Ready is a function of registered state only, so no combinational path
  // runs from the core's tready back to either source.
  assign w_pio_tready = (r_state == GNT_PIO) && (r_cnt != CNT_FULL);
  assign w_inj_tready = (r_state == GNT_INJ) && (r_cnt != CNT_FULL);

  assign w_pio_acc = tx.pio_tx_tvalid && w_pio_tready;
  assign w_inj_acc = tx.inj_tx_tvalid && w_inj_tready;
  assign w_push    = w_pio_acc || w_inj_acc;
  assign w_pop     = (r_cnt != 2'd0) && tx.out_tx_tready;

  // Select the granted source's beat for the skid buffer write port.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves
    // a variable unassigned would otherwise infer a latch.
    w_in_beat = '0;
    if (r_state == GNT_INJ) begin
      w_in_beat.last = tx.inj_tx_tlast;
      w_in_beat.keep = tx.inj_tx_tkeep;
      w_in_beat.data = tx.inj_tx_tdata;
      w_in_beat.user = tx.inj_tx_tuser;
    end else begin
      w_in_beat.last = tx.pio_tx_tlast;
      w_in_beat.keep = tx.pio_tx_tkeep;
      w_in_beat.data = tx.pio_tx_tdata;
      w_in_beat.user = tx.pio_tx_tuser;
    end
  end

  // Next-state and rr pointer: grants only from IDLE, release on tlast.
  always_comb begin
    w_state_nxt   = r_state;
    w_rr_last_nxt = r_rr_last;
    case (r_state)
      IDLE: begin
        if (lnk_up) begin
`ifdef PCIE_TX_ARB_PIO_PRIO_EN
          if (tx.pio_tx_req) begin
            w_state_nxt   = GNT_PIO;
            w_rr_last_nxt = SRC_PIO;
          end else if (tx.inj_tx_tvalid) begin
            w_state_nxt   = GNT_INJ;
            w_rr_last_nxt = SRC_INJ;
          end
`else
          // On a tie the source that did not win last time goes first.
          if (tx.pio_tx_req && (!tx.inj_tx_tvalid || (r_rr_last == SRC_INJ))) begin
            w_state_nxt   = GNT_PIO;
            w_rr_last_nxt = SRC_PIO;
          end else if (tx.inj_tx_tvalid) begin
            w_state_nxt   = GNT_INJ;
            w_rr_last_nxt = SRC_INJ;
          end
`endif
        end
      end
      GNT_PIO: begin
        if (w_pio_acc && tx.pio_tx_tlast) begin
          w_state_nxt = IDLE;
        end
      end
      GNT_INJ: begin
        if (w_inj_acc && tx.inj_tx_tlast) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Arbiter registers; pio_tx_ack is a registered copy of the PIO grant.
  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      r_state   <= IDLE;
      r_rr_last <= SRC_INJ;
      r_pio_ack <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      r_state   <= w_state_nxt;
      r_rr_last <= w_rr_last_nxt;
      r_pio_ack <= (w_state_nxt == GNT_PIO);
    end
  end

  // Skid buffer: 2-entry circular FIFO; reset discards any buffered beats.
  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      // NOTE: the two entries are reset because the head entry drives the
      // output pins directly and those must read 0 during reset.
      r_mem    <= '{default: '0};
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_in_beat;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  assign tx.pio_tx_ack    = r_pio_ack;
  assign tx.pio_tx_tready = w_pio_tready;
  assign tx.inj_tx_tready = w_inj_tready;

  assign tx.out_tx_tvalid = (r_cnt != 2'd0);
  assign tx.out_tx_tlast  = w_head.last;
  assign tx.out_tx_tkeep  = w_head.keep;
  assign tx.out_tx_tdata  = w_head.data;
  assign tx.out_tx_tuser  = w_head.user;

`ifndef SYNTHESIS
  // Only one source can ever be accepting, and the buffer never overfills.
  a_single_push : assert property (@(posedge pcie_clk) disable iff (!pcie_rst_n)
    !(w_pio_acc && w_inj_acc));
  a_cnt_bound   : assert property (@(posedge pcie_clk) disable iff (!pcie_rst_n)
    r_cnt <= CNT_FULL);
`endif

endmodule

// File: doc/pcie_tx_arbiter.md
Name: pcie_tx_arbiter

Overview:
- Merges two 64-bit AXI4-Stream TLP sources into the single transmit stream of the PCIe hard-core wrapper.
  - Source 1 (PIO): the local PIO completion engine, using a req/ack handshake.
  - Source 2 (INJ): TLPs injected from the Ethernet side.
- Arbitrates only at packet boundaries, round-robin, and never interleaves beats of different TLPs.
- Output passes through a 2-entry skid buffer for timing closure; the output drives the core's s_axis_tx port directly.

Parameters:
- C_DATA_WIDTH, 64, TLP data width in bits.
- KEEP_WIDTH, C_DATA_WIDTH/8, byte-enable width.

Ports:
- pcie_clk  in  1  user clock from the PCIe core; all logic is on this clock.
- pcie_rst_n  in  1  reset, asynchronous assert, active-low.
- lnk_up  in  1  registered link-up; when low, no new grants are issued.
- pio_tx_req  in  1  PIO requests the TX path.
- pio_tx_ack  out  1  grant to PIO; high from grant until PIO's tlast beat is accepted.
- pio_tx_tready  out  1  ready to PIO.
- pio_tx_tvalid / pio_tx_tlast  in  1 / 1  PIO stream valid and last.
- pio_tx_tkeep / pio_tx_tdata / pio_tx_tuser  in  KEEP_WIDTH / C_DATA_WIDTH / 4  PIO stream keep, data, user.
- inj_tx_tready  out  1  ready to INJ.
- inj_tx_tvalid / inj_tx_tlast  in  1 / 1  INJ stream valid and last; tvalid doubles as INJ's request.
- inj_tx_tkeep / inj_tx_tdata / inj_tx_tuser  in  KEEP_WIDTH / C_DATA_WIDTH / 4  INJ stream keep, data, user.
- out_tx_tready  in  1  ready from the core.
- out_tx_tvalid / out_tx_tlast  out  1 / 1  output stream valid and last.
- out_tx_tkeep / out_tx_tdata / out_tx_tuser  out  KEEP_WIDTH / C_DATA_WIDTH / 4  output stream keep, data, user.

Behaviour:
- Reset: asynchronous, active-low (pcie_rst_n = 0).
  - All outputs 0, skid buffer count 0, state IDLE, rr_last = INJ, so PIO wins the first tie.
  - Assertion mid-packet truncates immediately: out_tx_tvalid drops in the same cycle and buffered beats are discarded.
- State machine: IDLE, GNT_PIO, GNT_INJ.
  - IDLE with lnk_up = 1:
    - Only pio_tx_req high: go GNT_PIO.
    - Only inj_tx_tvalid high: go GNT_INJ.
    - Both high: grant the source other than rr_last.
    - On any grant, rr_last is set to the granted source.
  - Grant latency: 1 cycle. A request sampled in IDLE at cycle N gives grant state at N+1; pio_tx_ack is registered and rises at N+1.
  - IDLE with lnk_up = 0: stay in IDLE, both treadys low.
  - GNT_x leaves only when a beat with tlast=1 is accepted from source x; it then returns to IDLE. There is one idle cycle between consecutive packets.
  - lnk_up falling while in GNT_x does not abort the packet; it completes normally.
  - pio_tx_req dropping before tlast has no effect; the grant holds until tlast.
- Ready and acceptance:
  - src_tready = (state == GNT_src) && (cnt < 2); it is combinational from registered state and count. The non-granted source's tready is 0.
  - A beat is accepted when tvalid && tready. Gaps (tvalid low) inside a granted packet are allowed and the grant is held.
- Skid buffer:
  - 2-entry FIFO of {tlast, tkeep, tdata, tuser}.
  - out_tx_tvalid = (cnt != 0); outputs show the head entry.
  - Pop on out_tx_tvalid && out_tx_tready.
  - Push and pop in the same cycle: cnt unchanged.
  - cnt never exceeds 2; it is full when cnt = 2, and then src_tready = 0.
  - Latency: a beat accepted at cycle N appears on out_tx_* at N+1 when cnt was 0.
  - Throughput: with the core ready continuously, 1 beat/cycle within a packet.
- Pass-through: tuser/tkeep/tdata/tlast are passed unmodified; the block neither inspects nor modifies TLP headers.
- Output stability: out_tx_* stays stable while out_tx_tvalid = 1 and out_tx_tready = 0 (AXI rule).

Optional Feature:
- Macro: PCIE_TX_ARB_PIO_PRIO_EN.
- Defined: strict priority. In IDLE, PIO wins whenever pio_tx_req = 1, and rr_last is ignored. This keeps completion latency bounded for host reads.
- Undefined: round-robin as described above.

Test Plan:
- Reset, then single PIO 3-beat TLP (pio_tx_req=1, data 0x11..,0x22..,0x33..; tlast on beat 3) -> pio_tx_ack rises 1 cycle after req; out_tx_tdata shows 0x11,0x22,0x33 on consecutive cycles one cycle after acceptance; pio_tx_ack falls after beat 3 is accepted.
- PIO and INJ both request continuously, 2-beat packets each -> output order PIO, INJ, PIO, INJ with one idle cycle between packets. With PCIE_TX_ARB_PIO_PRIO_EN defined, only PIO packets appear.
- out_tx_tready held low for 5 cycles during a 4-beat INJ packet -> cnt reaches 2; inj_tx_tready = 0; out_tx_* stable; all 4 beats are delivered in order after tready returns; no loss or duplication.
- INJ drops tvalid for 3 cycles mid-packet while PIO requests -> grant stays on INJ; PIO is granted only after INJ's tlast.
- lnk_up = 0 with both sources requesting -> no grant, both treadys 0. lnk_up = 0 asserted mid-PIO packet -> the packet completes, then the block stays in IDLE.
- pcie_rst_n pulsed low during the 2nd beat of a 4-beat packet -> out_tx_tvalid = 0 and pio_tx_ack = 0 immediately; after release the next packet is granted cleanly.
